// File: rtl/trunc_share_pkg.sv
// Shared types and helpers for trunc_share_ctrl: FSM states, shift clamping, output saturation bounds.
package trunc_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Shifting past in_w - out_w would only discard bits the output cannot use.
  function automatic int clamp_shift(input int shift, input int in_w, input int out_w);
    int lim;
    lim = in_w - out_w;
    return (shift > lim) ? lim : shift;
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/trunc_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, searching cyclically.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/trunc_share_ctrl.sv
// Shared shift-and-truncate datapath with round-robin arbitration and per-job transfer counting.
// Define TRUNC_SATURATE_EN to clamp out-of-range results instead of wrapping.
module trunc_share_ctrl
  import trunc_share_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int DATA_IN_BITWIDTH  = 32,
  parameter int DATA_OUT_BITWIDTH = 8,
  parameter int SHIFT_W           = 5,
  parameter int COUNT_W           = 16,
  parameter int ID_W              = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [COUNT_W-1:0]                  cfg_num_items,
  input  logic [SHIFT_W-1:0]                  cfg_shift,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*DATA_IN_BITWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                out_valid,
  output logic [DATA_OUT_BITWIDTH-1:0]        out_data,
  output logic [ID_W-1:0]                     out_id,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  state_t                        state_q, state_d;
  logic [COUNT_W-1:0]            count_q, num_items_q;
  logic [SHIFT_W-1:0]            shift_q;
  logic [ID_W-1:0]               ptr_q;
  logic [NUM_REQ-1:0]            grant;
  logic [ID_W-1:0]               grant_idx;
  logic                          arb_en, xfer;
  logic [DATA_IN_BITWIDTH-1:0]   sel_data;
  logic [DATA_OUT_BITWIDTH-1:0]  trunc;

  assign arb_en    = (state_q == RUN) && (count_q != num_items_q) && (!out_valid || out_ready);
  assign xfer      = |grant;
  assign req_ready = grant;
  assign sel_data  = req_data[int'(grant_idx)*DATA_IN_BITWIDTH +: DATA_IN_BITWIDTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (arb_en),
    .grant  (grant),
    .idx    (grant_idx)
  );

`ifdef TRUNC_SATURATE_EN
  localparam logic signed [DATA_IN_BITWIDTH-1:0] OUT_MAX = DATA_IN_BITWIDTH'(sat_max(DATA_OUT_BITWIDTH));
  localparam logic signed [DATA_IN_BITWIDTH-1:0] OUT_MIN = DATA_IN_BITWIDTH'(sat_min(DATA_OUT_BITWIDTH));

  logic signed [DATA_IN_BITWIDTH-1:0] shifted;

  always_comb begin
    shifted = $signed(sel_data) >>> shift_q;
    if (shifted > OUT_MAX) begin
      trunc = OUT_MAX[DATA_OUT_BITWIDTH-1:0];
    end else if (shifted < OUT_MIN) begin
      trunc = OUT_MIN[DATA_OUT_BITWIDTH-1:0];
    end else begin
      trunc = shifted[DATA_OUT_BITWIDTH-1:0];
    end
  end
`else
  always_comb begin
    trunc = DATA_OUT_BITWIDTH'($signed(sel_data) >>> shift_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      num_items_q <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        num_items_q <= cfg_num_items;
        shift_q     <= SHIFT_W'(clamp_shift(int'(cfg_shift), DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH));
        count_q     <= '0;
      end else if (xfer) begin
        count_q <= count_q + COUNT_W'(1);
      end
      // Data/id are only rewritten on a new transfer so a stalled item stays stable.
      if (xfer) begin
        ptr_q     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        out_valid <= 1'b1;
        out_data  <= trunc;
        out_id    <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (start) state_d = (cfg_num_items == '0) ? DONE : RUN;
      RUN:     if (count_q == num_items_q) state_d = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trunc_share_ctrl.sv
// Directed testbench for trunc_share_ctrl; expectations follow TRUNC_SATURATE_EN when it is defined.
module tb_trunc_share_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  cfg_num_items;
  logic [4:0]   cfg_shift;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_id;
  logic         out_ready;
  logic         busy;
  logic         done;

  int           n_checks = 0;
  int           n_errors = 0;
  int           q_id[$];
  int           q_data[$];
  int           n_done;
  int           done_cycle;
  int           first_cycle;
  int           last_cycle;
  logic [3:0]   grant_seen;

  always #5 clk = ~clk;

  trunc_share_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_num_items (cfg_num_items),
    .cfg_shift     (cfg_shift),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_id        (out_id),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one clock; returns on the negedge after the start edge.
  task automatic applyStimulus(input logic [15:0] items, input logic [4:0] shift);
    @(negedge clk);
    cfg_num_items = items;
    cfg_shift     = shift;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Samples every negedge from now until busy falls; k = 0 is the current negedge.
  task automatic collectJob(input int max_cycles);
    bit seen_busy;
    bit finished;
    seen_busy   = 1'b0;
    finished    = 1'b0;
    q_id.delete();
    q_data.delete();
    n_done      = 0;
    done_cycle  = -1;
    first_cycle = -1;
    last_cycle  = -1;
    grant_seen  = '0;
    for (int k = 0; k < max_cycles && !finished; k++) begin
      checkOutput("req_ready onehot0", 32'($onehot0(req_ready)), 32'd1);
      grant_seen |= req_ready;
      if (out_valid && out_ready) begin
        q_id.push_back(int'(out_id));
        q_data.push_back(int'(out_data));
        if (first_cycle < 0) first_cycle = k;
        last_cycle = k;
      end
      if (done) begin
        n_done++;
        done_cycle = k;
      end
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) finished = 1'b1;
      if (!finished) @(negedge clk);
    end
    checkOutput("job terminates", 32'(finished), 32'd1);
  endtask

  task automatic doSingle(input string tag, input logic [31:0] data, input logic [4:0] shift,
                          input logic [7:0] expected);
    req_valid        = 4'b0100;
    req_data         = '0;
    req_data[64+:32] = data;
    applyStimulus(16'd1, shift);
    collectJob(20);
    checkOutput({tag, " count"}, 32'(q_id.size()), 32'd1);
    if (q_id.size() > 0) begin
      checkOutput({tag, " id"}, 32'(q_id[0]), 32'd2);
      checkOutput({tag, " data"}, 32'(q_data[0]), 32'(expected));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_ids[8];
    exp_ids       = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset         = 1'b1;
    start         = 1'b0;
    cfg_num_items = '0;
    cfg_shift     = '0;
    req_valid     = '0;
    req_data      = '0;
    out_ready     = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset out_id", 32'(out_id), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    // Round-robin with all requesters valid; requester i yields i+1 after shift 8.
    req_data  = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req_valid = 4'hF;
    applyStimulus(16'd8, 5'd8);
    collectJob(40);
    checkOutput("rr count", 32'(q_id.size()), 32'd8);
    for (int i = 0; i < q_id.size() && i < 8; i++) begin
      checkOutput($sformatf("rr id[%0d]", i), 32'(q_id[i]), 32'(exp_ids[i]));
      checkOutput($sformatf("rr data[%0d]", i), 32'(q_data[i]), 32'(exp_ids[i] + 1));
    end
    checkOutput("rr first cycle", 32'(first_cycle), 32'd1);
    checkOutput("rr back-to-back", 32'(last_cycle - first_cycle), 32'd7);
    checkOutput("rr done pulses", 32'(n_done), 32'd1);
    checkOutput("rr done cycle", 32'(done_cycle), 32'd10);

    // Backpressure: first item stalls for three cycles.
    out_ready = 1'b0;
    applyStimulus(16'd4, 5'd8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp out_id c%0d", c), 32'(out_id), 32'd0);
      checkOutput($sformatf("bp out_data c%0d", c), 32'(out_data), 32'd1);
      checkOutput($sformatf("bp req_ready c%0d", c), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    collectJob(30);
    checkOutput("bp count", 32'(q_id.size()), 32'd4);
    for (int i = 0; i < q_id.size() && i < 4; i++) begin
      checkOutput($sformatf("bp id[%0d]", i), 32'(q_id[i]), 32'(i));
      checkOutput($sformatf("bp data[%0d]", i), 32'(q_data[i]), 32'(i + 1));
    end
    checkOutput("bp done pulses", 32'(n_done), 32'd1);

    // Reset while an item sits in the output register.
    applyStimulus(16'd8, 5'd8);
    @(negedge clk);
    checkOutput("midreset pre out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset req_ready", 32'(req_ready), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("postreset done c%0d", c), 32'(done), 32'd0);
      checkOutput($sformatf("postreset busy c%0d", c), 32'(busy), 32'd0);
    end

    // Arithmetic through requester 2.
    doSingle("arith 1234", 32'h0000_1234, 5'd8, 8'h12);
`ifdef TRUNC_SATURATE_EN
    doSingle("arith pos ovf", 32'h0012_3400, 5'd8, 8'h7F);
    doSingle("arith neg ovf", 32'hFFF0_0000, 5'd8, 8'h80);
`else
    doSingle("arith pos ovf", 32'h0012_3400, 5'd8, 8'h34);
    doSingle("arith neg ovf", 32'hFFF0_0000, 5'd8, 8'h00);
`endif
    doSingle("arith minus one", 32'hFFFF_FF00, 5'd8, 8'hFF);
    doSingle("clamp pos", 32'h7F00_0000, 5'd31, 8'h7F);
    doSingle("clamp neg", 32'h8000_0000, 5'd31, 8'h80);

    // Zero-item job goes straight to DONE.
    req_data  = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req_valid = 4'hF;
    applyStimulus(16'd0, 5'd3);
    collectJob(10);
    checkOutput("zero count", 32'(q_id.size()), 32'd0);
    checkOutput("zero done pulses", 32'(n_done), 32'd1);
    checkOutput("zero done cycle", 32'(done_cycle), 32'd0);
    checkOutput("zero grants", 32'(grant_seen), 32'd0);

    // Item limit stops grants even though all requesters stay valid.
    applyReset();
    applyStimulus(16'd2, 5'd8);
    collectJob(20);
    checkOutput("limit count", 32'(q_id.size()), 32'd2);
    for (int i = 0; i < q_id.size() && i < 2; i++) begin
      checkOutput($sformatf("limit id[%0d]", i), 32'(q_id[i]), 32'(i));
    end
    checkOutput("limit grants", 32'(grant_seen), 32'h3);
    checkOutput("limit done pulses", 32'(n_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
